hazard_stall_controller: RTL and testbench

Pipeline hazard and stall sequencer for the 5-stage processor, sitting beside the forwarding logic between the IF/ID, ID/EX and EX/MEM pipeline registers. It detects load-use hazards that forwarding cannot cover and inserts one bubble. It flushes the wrong-path instruction on a taken branch. It freezes the front of the pipeline for the fixed latency of the iterative multiply/divide unit. A saturating stall-cycle counter is kept for performance measurement.

---
 rtl/hazard_pkg.sv | 11 +
 rtl/hazard_stall_controller_if.sv | 41 ++++
 rtl/hazard_stall_controller_load_use_detect.sv | 21 ++
 rtl/hazard_stall_controller.sv | 107 ++++++++++
 tb/tb_hazard_stall_controller.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/stall controller.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    MULDIV = 1'b1
  } hazard_state_e;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side hazard inputs and pipeline-register control outputs.
// Handshake: none; every control output is a same-cycle combinational decode of the inputs and controller state.
interface hazard_stall_controller_if #(
  parameter int STALL_CNT_W = 16
);
  import hazard_pkg::*;

  logic [REG_ADDR_W-1:0]  ID_Rs;
  logic [REG_ADDR_W-1:0]  ID_Rt;
  logic                   ID_UsesRt;
  logic                   ID_EX_MemRead;
  logic [REG_ADDR_W-1:0]  ID_EX_RegisterRt;
  logic                   ID_EX_MulDiv;
  logic                   EX_BranchTaken;

  logic                   PCWrite;
  logic                   IF_ID_Write;
  logic                   IF_ID_Flush;
  logic                   ID_EX_Write;
  logic                   ID_EX_Bubble;
  logic                   EX_MEM_Bubble;
  logic                   MulDivStart;
  logic                   Busy;
  logic [STALL_CNT_W-1:0] StallCycles;

  // master: the pipeline datapath; slave: the hazard controller
  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, ID_EX_MemRead, ID_EX_RegisterRt,
           ID_EX_MulDiv, EX_BranchTaken,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble,
           EX_MEM_Bubble, MulDivStart, Busy, StallCycles
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, ID_EX_MemRead, ID_EX_RegisterRt,
           ID_EX_MulDiv, EX_BranchTaken,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble,
           EX_MEM_Bubble, MulDivStart, Busy, StallCycles
  );

endinterface

// File: rtl/hazard_stall_controller_load_use_detect.sv
// Load-use hazard detect: a load in EX whose destination is read by the instruction in ID.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rt_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  output logic                  lu_o
);

  logic rs_match;
  logic rt_match;

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign rs_match = (ex_rt_i == id_rs_i);
  assign rt_match = id_uses_rt_i && (ex_rt_i == id_rt_i);
  assign lu_o     = ex_mem_read_i && (ex_rt_i != '0) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_stall_controller.sv
// Hazard and stall sequencer: load-use bubble, taken-branch flush, mul/div freeze
// and a saturating count of cycles in which the PC is held.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4,
  parameter int STALL_CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  hazard_stall_controller_if.slave bus,
  output logic [0:0]               dbg_state_o
);

  localparam logic [7:0] CNT_LOAD = 8'(MULDIV_CYCLES - 1);
  localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  hazard_state_e          state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [STALL_CNT_W-1:0] stall_q;

  logic lu;
  logic pc_write, if_id_write, if_id_flush, id_ex_write;
  logic id_ex_bubble, ex_mem_bubble, muldiv_start, busy;

  load_use_detect u_load_use_detect (
    .id_rs_i       (bus.ID_Rs),
    .id_rt_i       (bus.ID_Rt),
    .id_uses_rt_i  (bus.ID_UsesRt),
    .ex_mem_read_i (bus.ID_EX_MemRead),
    .ex_rt_i       (bus.ID_EX_RegisterRt),
    .lu_o          (lu)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    muldiv_start  = 1'b0;
    busy          = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.EX_BranchTaken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (bus.ID_EX_MulDiv) begin
          muldiv_start  = 1'b1;
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          cnt_d         = CNT_LOAD;
          state_d       = MULDIV;
        end else if (lu) begin
          // the bubble clears MemRead in EX next cycle, ending the stall
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
      MULDIV: begin
        busy = 1'b1;
        if (cnt_q != 8'd0) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          cnt_d         = cnt_q - 8'd1;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_write && (stall_q != '1)) begin
        stall_q <= stall_q + STALL_ONE;
      end
    end
  end

  assign bus.PCWrite       = pc_write;
  assign bus.IF_ID_Write   = if_id_write;
  assign bus.IF_ID_Flush   = if_id_flush;
  assign bus.ID_EX_Write   = id_ex_write;
  assign bus.ID_EX_Bubble  = id_ex_bubble;
  assign bus.EX_MEM_Bubble = ex_mem_bubble;
  assign bus.MulDivStart   = muldiv_start;
  assign bus.Busy          = busy;
  assign bus.StallCycles   = stall_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: directed test-plan cases plus random traffic
// against a cycle-schedule reference model; a second instance exercises counter saturation.
module tb_hazard_stall_controller;

  localparam int M   = 4;
  localparam int M2  = 255;
  localparam int W   = 16;
  localparam longint SAT = (64'd1 << W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_stall_controller_if #(.STALL_CNT_W(W)) bus ();
  hazard_stall_controller_if #(.STALL_CNT_W(W)) bus2 ();
  logic [0:0] dbg_state;
  logic [0:0] dbg_state2;

  hazard_stall_controller #(.MULDIV_CYCLES(M), .STALL_CNT_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  hazard_stall_controller #(.MULDIV_CYCLES(M2), .STALL_CNT_W(W)) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus2),
    .dbg_state_o (dbg_state2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a mul/div accepted in cycle mstart freezes the front end
  // through mstart+M-1 and releases in mstart+M.
  int     cyc     = 0;
  int     mstart  = 0;
  bit     mactive = 1'b0;
  longint mstall  = 0;

  // Expected vector: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
  //                   ID_EX_Bubble, EX_MEM_Bubble, MulDivStart, Busy}
  function automatic logic [7:0] observed();
    return {bus.PCWrite, bus.IF_ID_Write, bus.IF_ID_Flush, bus.ID_EX_Write,
            bus.ID_EX_Bubble, bus.EX_MEM_Bubble, bus.MulDivStart, bus.Busy};
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge; applies inputs, checks at the falling edge.
  task automatic run_cycle(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                           input logic memrd, input logic [4:0] ldrt,
                           input logic muldiv, input logic br);
    logic [7:0]  e;
    logic        lu;
    logic [31:0] exp_sc;
    bus.ID_Rs            = rs;
    bus.ID_Rt            = rt;
    bus.ID_UsesRt        = uses_rt;
    bus.ID_EX_MemRead    = memrd;
    bus.ID_EX_RegisterRt = ldrt;
    bus.ID_EX_MulDiv     = muldiv;
    bus.EX_BranchTaken   = br;

    lu = memrd && (ldrt != 5'd0) && ((ldrt == rs) || (uses_rt && (ldrt == rt)));
    if (rst) begin
      mactive = 1'b0;
      mstall  = 0;
    end
    if (mactive && (cyc < mstart + M)) begin
      e = 8'b0000_0101;
    end else if (mactive && (cyc == mstart + M)) begin
      e = 8'b1101_0001;
      mactive = 1'b0;
    end else if (br) begin
      e = 8'b1111_1000;
    end else if (muldiv) begin
      e = 8'b0000_0110;
      if (!rst) begin
        mactive = 1'b1;
        mstart  = cyc;
      end
    end else if (lu) begin
      e = 8'b0001_1000;
    end else begin
      e = 8'b1101_0000;
    end
    exp_q.push_back(e);
    exp_sc = 32'(mstall);

    @(negedge clk);
    check("ctl", 32'(observed()), 32'(exp_q.pop_front()));
    check("stall_cnt", 32'(bus.StallCycles), exp_sc);

    if (!e[7] && !rst) mstall = (mstall + 1 > SAT) ? SAT : mstall + 1;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    run_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] sc0;
    bus2.ID_Rs            = '0;
    bus2.ID_Rt            = '0;
    bus2.ID_UsesRt        = 1'b0;
    bus2.ID_EX_MemRead    = 1'b0;
    bus2.ID_EX_RegisterRt = '0;
    bus2.ID_EX_MulDiv     = 1'b1;
    bus2.EX_BranchTaken   = 1'b0;

    @(posedge clk);
    #1;
    idle_cycle();
    idle_cycle();
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    idle_cycle();

    // load-use on Rs: single-cycle stall
    run_cycle(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    idle_cycle();
    check("lu_stall_cnt", 32'(bus.StallCycles), 32'd1);
    // Rt match but immediate form, then load into r0
    run_cycle(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    run_cycle(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    check("no_stall_cnt", 32'(bus.StallCycles), 32'd1);

    // back-to-back mul/div: second start at T+5, 8 stall cycles in total
    sc0 = 32'(bus.StallCycles);
    for (int i = 0; i < 10; i++) begin
      run_cycle(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, (i <= 5), 1'b0);
      if (i == 4) check("md1_cnt", 32'(bus.StallCycles) - sc0, 32'd4);
    end
    check("md2_cnt", 32'(bus.StallCycles) - sc0, 32'd8);
    check("md_done_busy", 32'(bus.Busy), 32'd0);

    // taken branch wins over load-use
    sc0 = 32'(bus.StallCycles);
    run_cycle(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1);
    check("br_no_stall", 32'(bus.StallCycles), sc0);

    // reset at T+2 of a mul/div
    run_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    run_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    rst = 1'b1;
    idle_cycle();
    check("rst_abort_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    idle_cycle();
    run_cycle(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    idle_cycle();
    check("post_rst_lu", 32'(bus.StallCycles), 32'd1);

    // random traffic, small register range to provoke hazards
    for (int i = 0; i < 600; i++) begin
      logic [4:0] rs, rt, ldrt;
      logic uses_rt, memrd, muldiv, br;
      rs      = 5'($urandom_range(0, 3));
      rt      = 5'($urandom_range(0, 3));
      ldrt    = 5'($urandom_range(0, 3));
      uses_rt = 1'($urandom_range(0, 1));
      memrd   = 1'($urandom_range(0, 1));
      muldiv  = ($urandom_range(0, 7) == 0);
      br      = ($urandom_range(0, 5) == 0);
      rst     = ($urandom_range(0, 99) == 0);
      run_cycle(rs, rt, uses_rt, memrd, ldrt, muldiv, br);
    end
    rst = 1'b0;

    // saturation: dut_sat stalls 255 of every 256 cycles since the last reset
    repeat (66200) @(posedge clk);
    @(negedge clk);
    check("sat_cnt", 32'(bus2.StallCycles), 32'(SAT));
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("sat_hold", 32'(bus2.StallCycles), 32'(SAT));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // global time bound
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
